// File: rtl/cpu_tx_handshake.sv
// CPU-side transmitter: sends FIFO or LFSR words to a peripheral over a
// four-phase send/ack handshake, with a REQ timeout that retries the same word.
module cpu_tx_handshake #(
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 15,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              auto_mode,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    input  logic              ack,
    output logic              send,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       sent_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              send_q, send_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              timeout_err_q, timeout_err_d;
    logic [15:0]       sent_count_q, sent_count_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              src_mode_q, src_mode_d;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;
    logic [15:0]       lfsr_next;
    logic              tmo_hit;

    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign busy        = (state_q != IDLE);
    assign send        = send_q;
    assign data        = data_q;
    assign timeout_err = timeout_err_q;
    assign sent_count  = sent_count_q;

    assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign tmo_hit   = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    // State register and all handshake flops; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            send_q        <= 1'b0;
            data_q        <= '0;
            timeout_err_q <= 1'b0;
            sent_count_q  <= '0;
            lfsr_q        <= LFSR_SEED;
            tmo_cnt_q     <= '0;
            src_mode_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            send_q        <= send_d;
            data_q        <= data_d;
            timeout_err_q <= timeout_err_d;
            sent_count_q  <= sent_count_d;
            lfsr_q        <= lfsr_d;
            tmo_cnt_q     <= tmo_cnt_d;
            src_mode_q    <= src_mode_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (auto_mode || !empty) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    state_d = WAIT_LOW;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; a timeout leaves the FIFO and LFSR untouched.
    always_comb begin
        send_d        = send_q;
        data_d        = data_q;
        timeout_err_d = 1'b0;
        sent_count_d  = sent_count_q;
        lfsr_d        = lfsr_q;
        tmo_cnt_d     = tmo_cnt_q;
        src_mode_d    = src_mode_q;
        pop           = 1'b0;
        case (state_q)
            IDLE: begin
                if (auto_mode) begin
                    data_d     = lfsr_q[DATA_W-1:0];
                    send_d     = 1'b1;
                    src_mode_d = 1'b1;
                    tmo_cnt_d  = '0;
                end else if (!empty) begin
                    data_d     = fifo_mem[rd_ptr_q];
                    send_d     = 1'b1;
                    src_mode_d = 1'b0;
                    tmo_cnt_d  = '0;
                end
            end
            REQ: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (ack) begin
                    send_d       = 1'b0;
                    sent_count_d = sent_count_q + 16'd1;
                    if (src_mode_q) begin
                        lfsr_d = lfsr_next;
                    end else begin
                        pop = 1'b1;
                    end
                end else if (tmo_hit) begin
                    send_d        = 1'b0;
                    timeout_err_d = 1'b1;
                end
            end
            default: begin
                send_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        push     = wr_en && !full;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

endmodule

// File: tb/tb_cpu_tx_handshake.sv
// Directed self-checking bench for cpu_tx_handshake with default parameters.
module tb_cpu_tx_handshake;

    logic        clk = 1'b0;
    logic        rst;
    logic        auto_mode;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        empty;
    logic        ack;
    logic        send;
    logic [7:0]  data;
    logic        busy;
    logic        timeout_err;
    logic [15:0] sent_count;

    int checks = 0;
    int errors = 0;

    cpu_tx_handshake #(
        .DATA_W    (8),
        .FIFO_DEPTH(4),
        .TIMEOUT   (15),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .auto_mode  (auto_mode),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .ack        (ack),
        .send       (send),
        .data       (data),
        .busy       (busy),
        .timeout_err(timeout_err),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        ack       = 1'b0;
        auto_mode = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_send(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (send === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bit ok;
        push_word(8'hA5);
        wait_send(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL reset_reach_req: send never rose"); end
        checks++;
        if (data !== 8'hA5) begin errors++; $display("[TB] FAIL reset_pre_data: got %h expected a5", data); end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (send !== 1'b0) begin errors++; $display("[TB] FAIL reset_send: got %b expected 0", send); end
        checks++;
        if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", data); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_fifo: empty %b full %b expected 1 0", empty, full); end
        checks++;
        if (sent_count !== 16'd0 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_count: cnt %0d terr %b expected 0 0", sent_count, timeout_err); end
    endtask

    task automatic test_single_word();
        bit ok;
        do_reset();
        push_word(8'hA5);
        wait_send(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL single_send_rise: send never rose"); end
        tick();
        tick();
        checks++;
        if (send !== 1'b1 || data !== 8'hA5) begin errors++; $display("[TB] FAIL single_hold: send %b data %h expected 1 a5", send, data); end
        ack = 1'b1;
        tick();
        checks++;
        if (send !== 1'b0 || busy !== 1'b1 || data !== 8'hA5) begin errors++; $display("[TB] FAIL single_waitlow: send %b busy %b data %h expected 0 1 a5", send, busy, data); end
        checks++;
        if (sent_count !== 16'd1 || empty !== 1'b1) begin errors++; $display("[TB] FAIL single_done: cnt %0d empty %b expected 1 1", sent_count, empty); end
        ack = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: busy %b expected 0", busy); end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            push_word(8'(i));
            if (i == 4) begin
                checks++;
                if (full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full4: full %b expected 1", full); end
            end
        end
        checks++;
        if (full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full5: full %b expected 1", full); end
        for (int i = 1; i <= 4; i++) begin
            wait_send(ok);
            checks++;
            if (!ok || data !== 8'(i)) begin errors++; $display("[TB] FAIL ovf_word%0d: ok %b data %h expected %h", i, ok, data, 8'(i)); end
            ack = 1'b1;
            tick();
            ack = 1'b0;
            if (i == 1) begin
                checks++;
                if (full !== 1'b0) begin errors++; $display("[TB] FAIL ovf_unfull: full %b expected 0", full); end
            end
            tick();
        end
        checks++;
        if (sent_count !== 16'd4 || empty !== 1'b1) begin errors++; $display("[TB] FAIL ovf_end: cnt %0d empty %b expected 4 1", sent_count, empty); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drop05: busy %b expected 0", busy); end
    endtask

    task automatic test_timeout();
        bit ok;
        int high;
        do_reset();
        push_word(8'h3C);
        wait_send(ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL tmo_send_rise: send never rose"); end
        high = 1;
        while (send === 1'b1 && high < 40) begin
            tick();
            if (send === 1'b1) high++;
        end
        checks++;
        if (high !== 15) begin errors++; $display("[TB] FAIL tmo_high_len: got %0d cycles expected 15", high); end
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL tmo_pulse: terr %b busy %b expected 1 0", timeout_err, busy); end
        checks++;
        if (empty !== 1'b0) begin errors++; $display("[TB] FAIL tmo_no_pop: empty %b expected 0", empty); end
        tick();
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_pulse_len: terr %b expected 0", timeout_err); end
        checks++;
        if (send !== 1'b1 || data !== 8'h3C) begin errors++; $display("[TB] FAIL tmo_retry: send %b data %h expected 1 3c", send, data); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        checks++;
        if (sent_count !== 16'd1 || empty !== 1'b1) begin errors++; $display("[TB] FAIL tmo_done: cnt %0d empty %b expected 1 1", sent_count, empty); end
    endtask

    task automatic test_auto_mode();
        bit ok;
        logic [7:0] exp_auto [3];
        exp_auto[0] = 8'hE1;
        exp_auto[1] = 8'h70;
        exp_auto[2] = 8'h38;
        do_reset();
        auto_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_send(ok);
            checks++;
            if (!ok || data !== exp_auto[i]) begin errors++; $display("[TB] FAIL auto_word%0d: ok %b data %h expected %h", i, ok, data, exp_auto[i]); end
            ack = 1'b1;
            tick();
            ack = 1'b0;
            if (i == 2) auto_mode = 1'b0;
            tick();
        end
        checks++;
        if (sent_count !== 16'd3 || busy !== 1'b0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL auto_end: cnt %0d busy %b empty %b expected 3 0 1", sent_count, busy, empty); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] exp_rest [3];
        exp_rest[0] = 8'h33;
        exp_rest[1] = 8'h44;
        exp_rest[2] = 8'h55;
        do_reset();
        push_word(8'h11);
        push_word(8'h22);
        checks++;
        if (send !== 1'b1 || data !== 8'h11) begin errors++; $display("[TB] FAIL b2b_first: send %b data %h expected 1 11", send, data); end
        ack     = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h33;
        tick();
        ack   = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (empty !== 1'b0 || full !== 1'b0 || sent_count !== 16'd1) begin errors++; $display("[TB] FAIL b2b_pushpop: empty %b full %b cnt %0d expected 0 0 1", empty, full, sent_count); end
        tick();
        push_word(8'h44);
        checks++;
        if (full !== 1'b0) begin errors++; $display("[TB] FAIL b2b_count3: full %b expected 0", full); end
        push_word(8'h55);
        checks++;
        if (full !== 1'b1) begin errors++; $display("[TB] FAIL b2b_count4: full %b expected 1", full); end
        wait_send(ok);
        checks++;
        if (!ok || data !== 8'h22) begin errors++; $display("[TB] FAIL b2b_second: ok %b data %h expected 22", ok, data); end
        ack     = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h66;
        tick();
        ack   = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (full !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_reject: full %b expected 0", full); end
        tick();
        for (int i = 0; i < 3; i++) begin
            wait_send(ok);
            checks++;
            if (!ok || data !== exp_rest[i]) begin errors++; $display("[TB] FAIL b2b_word%0d: ok %b data %h expected %h", i, ok, data, exp_rest[i]); end
            ack = 1'b1;
            tick();
            ack = 1'b0;
            tick();
        end
        checks++;
        if (empty !== 1'b1 || sent_count !== 16'd5) begin errors++; $display("[TB] FAIL b2b_end: empty %b cnt %0d expected 1 5", empty, sent_count); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single_word();
        test_overflow();
        test_timeout();
        test_auto_mode();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
